uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among `N_REQ` byte producers, such as the echo path, a status reporter and result formatters. It sits between the requesters and the `uart` core's TX interface (`tx_start`/`tx_data`/`tx_busy`). It grants one byte at a time, issues exactly one `tx_start` pulse per byte and waits for the frame to finish before granting again. A bounded wait on `tx_busy` rising keeps a dead transmitter from locking up the arbiter; a timeout sets a sticky error.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `BUSY_TIMEOUT`, default 16: max cycles to wait for `tx_busy` to rise after `tx_start`; legal range ≥ 2.
- `clk100mhz` input 1: 100 MHz system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `req_valid` input N_REQ: requester i has a byte pending.
- `req_data` input 8*N_REQ: byte of requester i in bits [8i+7:8i].
- `req_ready` output N_REQ: one-cycle accept pulse; at most one bit set.
- `tx_busy` input 1: from the UART core, high while a frame is on the line.
- `tx_start` output 1: one-cycle start pulse to the UART core.
- `tx_data` output 8: byte to the UART core; held until the next grant.
- `grant_id` output $clog2(N_REQ): index of the last granted requester.
- `active` output 1: high whenever the FSM is not in IDLE.
- `err_clr` input 1: clears `timeout_err`.
- `timeout_err` output 1: sticky; set when `tx_busy` failed to rise in time.

## Operation
- FSM states are IDLE, WAIT_BUSY and WAIT_DONE. All outputs are registered.
- Reset values:
  - state = IDLE.
  - `tx_start` = 0, `tx_data` = 8'h00, `req_ready` = 0, `grant_id` = 0, `active` = 0, `timeout_err` = 0.
  - Round-robin pointer `last` = N_REQ-1, so requester 0 has first priority.
- Requester protocol:
  - The requester holds `req_valid[i]` high and its `req_data` stable until it sees `req_ready[i]`.
  - It may drop `req_valid` earlier; an ungranted byte is then simply not sent.
  - After `req_ready[i]` it may present a new byte on the next cycle.
- IDLE, when `tx_busy`=0 and any `req_valid` bit is set:
  - The winner is the first set bit scanning (last+1) mod N_REQ upward with wrap.
  - Registered in the same edge: `tx_data` ← winner's byte, `tx_start` ← 1, `req_ready[winner]` ← 1, `grant_id` ← winner, `last` ← winner.
  - Next state is WAIT_BUSY.
- IDLE with `tx_busy`=1 (TX in use by something else) or no `req_valid` bit set: no grant; remain in IDLE.
- WAIT_BUSY:
  - A cycle counter starts at 0.
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise, when the counter reaches BUSY_TIMEOUT-1, set `timeout_err` and go to IDLE.
- WAIT_DONE: when `tx_busy`=0, go to IDLE.
- `tx_start` and `req_ready` are high for exactly one cycle per grant.
- `timeout_err`:
  - Cleared by `err_clr` (synchronous).
  - A set and a clear in the same cycle resolve to set.
  - The error does not block further arbitration.
- Reset mid-frame returns the FSM to IDLE immediately with all outputs at reset values. Bytes already accepted are not re-sent; requesters re-request.

## Timing
- Grant latency: request seen in IDLE at edge k → `tx_start`/`req_ready` high during cycle k+1.
- Back-to-back operation:
  - Edge j: WAIT_DONE samples `tx_busy`=0 and moves to IDLE.
  - Edge j+1: next grant is registered.
  - Result: one idle cycle between frames at the arbiter output.
- Throughput: one byte per UART frame plus 2 cycles; no requester waits more than N_REQ-1 other grants.
- Timeout: `timeout_err` is set BUSY_TIMEOUT cycles after the `tx_start` cycle when `tx_busy` never rises.

## Test plan
- Reset, then only requester 2 valid with byte 8'h41, and a UART model raising `tx_busy` 1 cycle after `tx_start` for 20 cycles:
  - exactly one `tx_start` with `tx_data`=8'h41;
  - `req_ready`=4'b0100 for 1 cycle;
  - `grant_id`=2;
  - FSM back to IDLE after `tx_busy` falls.
- All 4 requesters continuously valid (bytes 8'h10..8'h13) for 8 grants:
  - grant order 0,1,2,3,0,1,2,3;
  - one `tx_start` per frame;
  - 1 idle cycle between `tx_busy` falling and the next `tx_start`.
- Requesters 1 and 3 valid, `last`=1:
  - 3 wins, then 1 (wrap-around);
  - requester 1 drops `req_valid` before its grant → nothing further is sent.
- `tx_busy` held at 0 (dead UART), BUSY_TIMEOUT=16, request on requester 0:
  - `timeout_err` rises 16 cycles after `tx_start`;
  - the next request is still granted;
  - `err_clr` asserted in the same cycle as a second timeout leaves `timeout_err`=1.
- `tx_busy` held at 1 before any request: no grant while high; grant occurs 1 cycle after it drops.
- `rst` asserted while in WAIT_DONE:
  - outputs return to reset values asynchronously;
  - after release, requester 0 has priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among byte producers
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       clk100mhz,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       active,
  input  logic                       err_clr,
  output logic                       timeout_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [IW-1:0]     last, last_nx;
  logic [IW-1:0]     win;
  logic              win_found;
  logic [7:0]        win_byte;
  logic              tx_start_nx;
  logic [N_REQ-1:0]  req_ready_nx;
  logic [7:0]        tx_data_nx;
  logic [IW-1:0]     grant_id_nx;
  logic              active_nx;
  logic              err_set;
  logic              err_nx;

  // Pick the first pending requester after the last winner, wrapping around.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_found && req_valid[IW'((int'(last) + k) % N_REQ)]) begin
        win_found = 1'b1;
        win       = IW'((int'(last) + k) % N_REQ);
      end
    end
  end

  // Mux out the winner's byte.
  always_comb begin
    win_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IW'(i)) win_byte = req_data[8*i +: 8];
    end
  end

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    last_nx      = last;
    tx_start_nx  = 1'b0;
    req_ready_nx = '0;
    tx_data_nx   = tx_data;
    grant_id_nx  = grant_id;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && win_found) begin
          tx_data_nx   = win_byte;
          tx_start_nx  = 1'b1;
          req_ready_nx = N_REQ'(1) << win;
          grant_id_nx  = win;
          last_nx      = win;
          cnt_nx       = '0;
          state_nx     = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nx = WAIT_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          err_set  = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // A timeout landing in the same cycle as a clear keeps the error visible.
    err_nx    = err_set | (timeout_err & ~err_clr);
    active_nx = (state_nx != IDLE);
  end

  // State and output registers, asynchronously reset.
  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= IW'(N_REQ - 1);
      tx_start    <= 1'b0;
      req_ready   <= '0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      last        <= last_nx;
      tx_start    <= tx_start_nx;
      req_ready   <= req_ready_nx;
      tx_data     <= tx_data_nx;
      grant_id    <= grant_id_nx;
      active      <= active_nx;
      timeout_err <= err_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int BT = 16;

  logic           clk100mhz = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_busy;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [1:0]     grant_id;
  logic           active;
  logic           err_clr;
  logic           timeout_err;
  logic           uart_busy;
  logic           force_busy;

  assign tx_busy = uart_busy | force_busy;

  uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(BT)) dut (
    .clk100mhz(clk100mhz), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .grant_id(grant_id), .active(active), .err_clr(err_clr), .timeout_err(timeout_err)
  );

  always #5 clk100mhz = ~clk100mhz;

  int cyc = 0;
  always @(posedge clk100mhz) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // requester byte stores (driver side) and reference model stores
  logic [7:0] dmem [N][256];
  int         dhead [N];
  int         dtail [N];
  logic [7:0] mmem [N][256];
  int         mhead [N];
  int         mtail [N];
  int         m_last;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;
  exp_t expq[$];

  // requester engine: hold valid/data until accepted, then show the next byte
  logic [N-1:0] rdy_s;
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk100mhz);
      rdy_s = req_ready;
      @(posedge clk100mhz);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rdy_s[i] && dhead[i] < dtail[i]) dhead[i]++;
        req_valid[i] = dhead[i] < dtail[i];
        req_data[8*i +: 8] = dmem[i][dhead[i]];
      end
    end
  end

  // UART model: busy rises uart_dly cycles after tx_start, stays high uart_len cycles
  int uart_dly = 1;
  int uart_len = 4;
  bit uart_rand = 0;
  bit uart_dead = 0;
  bit uart_running = 0;
  initial begin
    int d;
    int l;
    uart_busy = 1'b0;
    forever begin
      @(negedge clk100mhz);
      if (tx_start && !uart_dead) begin
        uart_running = 1;
        d = uart_rand ? int'($urandom_range(1, 3)) : uart_dly;
        l = uart_rand ? int'($urandom_range(2, 8)) : uart_len;
        repeat (d) @(posedge clk100mhz);
        #1 uart_busy = 1'b1;
        repeat (l) @(posedge clk100mhz);
        #1 uart_busy = 1'b0;
        uart_running = 0;
      end
    end
  end

  // monitor: pop the expected grant on each tx_start and compare
  bit gap_chk = 0;
  initial begin
    bit   pulse_pend;
    bit   gap_armed;
    bit   prev_busy;
    int   fall_cyc;
    exp_t e;
    pulse_pend = 0;
    gap_armed  = 0;
    prev_busy  = 0;
    fall_cyc   = 0;
    forever begin
      @(negedge clk100mhz);
      if (pulse_pend) begin
        chk("pulse_width", {27'd0, tx_start, req_ready}, 32'd0);
        pulse_pend = 0;
      end
      if (gap_chk && prev_busy && !tx_busy) begin
        fall_cyc  = cyc;
        gap_armed = 1;
      end
      if (!gap_chk) gap_armed = 0;
      prev_busy = tx_busy;
      if (tx_start) begin
        pulse_pend = 1;
        if (gap_armed) begin
          chk("frame_gap", cyc - fall_cyc, 32'd2);
          gap_armed = 0;
        end
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got tx_data %0h grant_id %0d, expected no start", tx_data, grant_id);
        end else begin
          e = expq.pop_front();
          chk("tx_data", {24'd0, tx_data}, {24'd0, e.data});
          chk("grant_id", {30'd0, grant_id}, e.id);
          chk("req_ready", {28'd0, req_ready}, 32'd1 << e.id);
        end
      end
    end
  end

  task automatic add(input int i, input logic [7:0] b);
    dmem[i][dtail[i]] = b;
    dtail[i]++;
    mmem[i][mtail[i]] = b;
    mtail[i]++;
  endtask

  task automatic drv_add(input int i, input logic [7:0] b);
    dmem[i][dtail[i]] = b;
    dtail[i]++;
  endtask

  // reference: serve pending bytes one at a time, next requester after the last winner
  task automatic plan();
    bit any;
    do begin
      any = 0;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (!any && mhead[idx] < mtail[idx]) begin
          expq.push_back('{idx, mmem[idx][mhead[idx]]});
          mhead[idx]++;
          m_last = idx;
          any = 1;
        end
      end
    end while (any);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk100mhz);
      #1;
      n++;
    end while (!(expq.size() == 0 && !uart_running && !tx_busy) && n < 3000);
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d grants outstanding, expected 0", name, expq.size());
    end
    @(negedge clk100mhz);
    chk({name, "_idle"}, {31'd0, active}, 32'd0);
  endtask

  task automatic wait_start(input string name, output int c);
    int n;
    n = 0;
    do begin
      @(negedge clk100mhz);
      n++;
    end while (!tx_start && n < 200);
    if (!tx_start) begin
      checks++;
      errors++;
      $display("FAIL %s_start: got no tx_start, expected one", name);
    end
    c = cyc;
  endtask

  task automatic do_reset();
    @(posedge clk100mhz);
    #2 rst = 1'b1;
    m_last = N - 1;
    repeat (2) @(posedge clk100mhz);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int e;
    int d;
    int n;
    for (int i = 0; i < N; i++) begin
      dhead[i] = 0; dtail[i] = 0; mhead[i] = 0; mtail[i] = 0;
    end
    m_last = N - 1;
    rst = 1'b1;
    err_clr = 1'b0;
    force_busy = 1'b0;

    // reset values
    repeat (3) @(negedge clk100mhz);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(posedge clk100mhz);
    #1 rst = 1'b0;

    // single requester 2
    uart_dly = 1;
    uart_len = 20;
    @(negedge clk100mhz);
    add(2, 8'h41);
    plan();
    wait_drain("t1");
    chk("t1_data_held", {24'd0, tx_data}, 32'h41);

    // all four requesters, two bytes each, back to back
    do_reset();
    uart_len = 6;
    @(negedge clk100mhz);
    gap_chk = 1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) add(i, 8'(8'h10 + i));
    plan();
    wait_drain("t2");
    gap_chk = 0;

    // wrap-around, then requester 1 withdraws
    @(negedge clk100mhz);
    add(1, 8'h21);
    plan();
    wait_drain("t3a");
    @(negedge clk100mhz);
    add(3, 8'h33);
    add(1, 8'h31);
    plan();
    wait_drain("t3b");
    @(negedge clk100mhz);
    add(3, 8'h34);
    drv_add(1, 8'h35);
    plan();
    wait_start("t3c", s);
    dtail[1] = dhead[1];
    wait_drain("t3c");
    repeat (30) @(negedge clk100mhz);
    chk("t3_after_drop", {30'd0, grant_id}, 32'd3);

    // dead UART: timeout, continued arbitration, set beats clear
    uart_dead = 1;
    @(negedge clk100mhz);
    add(0, 8'h5a);
    plan();
    wait_start("t4a", s);
    n = 0;
    do begin
      @(negedge clk100mhz);
      n++;
    end while (!timeout_err && n < 100);
    e = cyc;
    chk("t4_timeout_latency", e - s, BT);
    chk("t4_idle_after_timeout", {31'd0, active}, 32'd0);
    @(posedge clk100mhz);
    #1 err_clr = 1'b1;
    @(posedge clk100mhz);
    #1 err_clr = 1'b0;
    @(negedge clk100mhz);
    chk("t4_err_cleared", {31'd0, timeout_err}, 32'd0);
    add(0, 8'h5b);
    plan();
    wait_start("t4b", s);
    repeat (BT - 1) @(posedge clk100mhz);
    #1 err_clr = 1'b1;
    @(posedge clk100mhz);
    #1 err_clr = 1'b0;
    @(negedge clk100mhz);
    chk("t4_set_beats_clear", {31'd0, timeout_err}, 32'd1);
    chk("t4_second_latency", cyc - s, BT);
    uart_dead = 0;

    // tx_busy held high by another user before the request
    @(negedge clk100mhz);
    force_busy = 1'b1;
    add(1, 8'h66);
    plan();
    n = 0;
    repeat (10) begin
      @(negedge clk100mhz);
      if (tx_start) n++;
    end
    chk("t5_no_grant_while_busy", n, 32'd0);
    @(posedge clk100mhz);
    #1 force_busy = 1'b0;
    d = cyc;
    wait_start("t5", s);
    chk("t5_grant_after_drop", s - d, 32'd1);
    wait_drain("t5");

    // randomized rounds
    uart_rand = 1;
    for (int r = 0; r < 25; r++) begin
      int mask;
      mask = int'($urandom_range(1, (1 << N) - 1));
      @(negedge clk100mhz);
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          int cnt;
          cnt = int'($urandom_range(1, 3));
          for (int b = 0; b < cnt; b++) add(i, 8'($urandom_range(0, 255)));
        end
      end
      plan();
      wait_drain("rand");
    end
    uart_rand = 0;

    // reset during WAIT_DONE
    uart_dly = 1;
    uart_len = 20;
    @(negedge clk100mhz);
    add(1, 8'h77);
    plan();
    wait_start("t7", s);
    repeat (5) @(posedge clk100mhz);
    #1;
    chk("t7_active_before_rst", {31'd0, active}, 32'd1);
    #1 rst = 1'b1;
    m_last = N - 1;
    #1;
    chk("t7_async_tx_data", {24'd0, tx_data}, 32'd0);
    chk("t7_async_grant_id", {30'd0, grant_id}, 32'd0);
    chk("t7_async_active", {31'd0, active}, 32'd0);
    chk("t7_async_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("t7_async_strobes", {27'd0, tx_start, req_ready}, 32'd0);
    repeat (2) @(posedge clk100mhz);
    #1 rst = 1'b0;
    wait_drain("t7a");
    @(negedge clk100mhz);
    for (int i = N - 1; i >= 0; i--) add(i, 8'(8'h80 + i));
    plan();
    wait_drain("t7b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
